// File: rtl/rv32i_load_store_unit.sv
// RV32I data-memory stage: turns core load/store requests into word-bus accesses with
// byte enables and a req/ack handshake, stalling the core until the access completes.
module rv32i_load_store_unit #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        sys_clk,
    input  logic        sys_reset,
    input  logic        memload_flag,
    input  logic        memstore_flag,
    input  logic [2:0]  func3,
    input  logic [31:0] mem_addr,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        done,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_bus_req;
    logic              r_bus_we;
    logic [31:0]       r_bus_addr;
    logic [3:0]        r_bus_be;
    logic [31:0]       r_bus_wdata;
    logic [31:0]       r_load_data;
    logic              r_done;
    logic              r_fault;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_func3;
    logic [1:0]        r_off;

    logic              w_bus_req_nxt;
    logic              w_done_nxt;
    logic              w_fault_nxt;
    logic [31:0]       w_load_data_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_capture;
    logic              w_stall;
    logic              w_f3_ok;
    logic              w_misaligned;
    logic              w_any_req;
    logic              w_req_ok;

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   lane_be = 4'b0001 << off;
            2'b01:   lane_be = 4'b0011 << {off[1], 1'b0};
            2'b10:   lane_be = 4'b1111;
            default: lane_be = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] sd);
        case (size)
            2'b00:   lane_wdata = {4{sd[7:0]}};
            2'b01:   lane_wdata = {2{sd[15:0]}};
            default: lane_wdata = sd;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  load_extend = {{24{b[7]}}, b};
            3'b001:  load_extend = {{16{h[15]}}, h};
            3'b010:  load_extend = word;
            3'b100:  load_extend = {24'h00_0000, b};
            3'b101:  load_extend = {16'h0000, h};
            default: load_extend = 32'h0000_0000;
        endcase
    endfunction

    assign w_any_req = memload_flag | memstore_flag;
    assign w_req_ok  = w_any_req & ~(memload_flag & memstore_flag) & w_f3_ok & ~w_misaligned;

    // Request legality: funct3 encoding for the access direction and natural alignment.
    always_comb begin
        w_f3_ok      = 1'b0;
        w_misaligned = 1'b0;
        if (memload_flag) begin
            case (func3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_f3_ok = 1'b1;
                default:                                w_f3_ok = 1'b0;
            endcase
        end else begin
            case (func3)
                3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
                default:                w_f3_ok = 1'b0;
            endcase
        end
        case (func3[1:0])
            2'b01:   w_misaligned = mem_addr[0];
            2'b10:   w_misaligned = (mem_addr[1:0] != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
    end

    // Next-state and handshake decisions; stall must react to the core in the same cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_bus_req_nxt   = r_bus_req;
        w_done_nxt      = 1'b0;
        w_fault_nxt     = 1'b0;
        w_load_data_nxt = 32'h0000_0000;
        w_cnt_nxt       = CNT_ZERO;
        w_capture       = 1'b0;
        w_stall         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_stall = w_any_req;
                if (w_req_ok) begin
                    w_capture     = 1'b1;
                    w_bus_req_nxt = 1'b1;
                    w_state_nxt   = ST_REQ;
                end else if (w_any_req) begin
                    w_done_nxt  = 1'b1;
                    w_fault_nxt = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                w_stall = 1'b1;
                if (bus_ack) begin
                    w_bus_req_nxt = 1'b0;
                    w_done_nxt    = 1'b1;
                    w_fault_nxt   = bus_err;
                    w_state_nxt   = ST_DONE;
                    if (!r_bus_we && !bus_err) begin
                        w_load_data_nxt = load_extend(r_func3, r_off, bus_rdata);
                    end else begin
                        w_load_data_nxt = 32'h0000_0000;
                    end
                end else if (r_cnt == CNT_LAST) begin
                    w_bus_req_nxt = 1'b0;
                    w_done_nxt    = 1'b1;
                    w_fault_nxt   = 1'b1;
                    w_state_nxt   = ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_bus_req_nxt = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bus request fields are captured once on acceptance and held for the whole access.
    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'h0000_0000;
            r_bus_be    <= 4'b0000;
            r_bus_wdata <= 32'h0000_0000;
            r_load_data <= 32'h0000_0000;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
            r_cnt       <= CNT_ZERO;
            r_func3     <= 3'b000;
            r_off       <= 2'b00;
        end else begin
            r_bus_req   <= w_bus_req_nxt;
            r_load_data <= w_load_data_nxt;
            r_done      <= w_done_nxt;
            r_fault     <= w_fault_nxt;
            r_cnt       <= w_cnt_nxt;
            if (w_capture) begin
                r_bus_we    <= memstore_flag;
                r_bus_addr  <= {mem_addr[31:2], 2'b00};
                r_bus_be    <= lane_be(func3[1:0], mem_addr[1:0]);
                r_bus_wdata <= memstore_flag ? lane_wdata(func3[1:0], store_data) : 32'h0000_0000;
                r_func3     <= func3;
                r_off       <= mem_addr[1:0];
            end else begin
                r_bus_we    <= r_bus_we;
                r_bus_addr  <= r_bus_addr;
                r_bus_be    <= r_bus_be;
                r_bus_wdata <= r_bus_wdata;
                r_func3     <= r_func3;
                r_off       <= r_off;
            end
        end
    end

    assign load_data = r_load_data;
    assign stall     = w_stall;
    assign done      = r_done;
    assign fault     = r_fault;
    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_be    = r_bus_be;
    assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_rv32i_load_store_unit.sv
// Scoreboard bench for rv32i_load_store_unit: a bus responder acks after a chosen number
// of request cycles; expected commit results are queued at issue and checked at done.
module tb_rv32i_load_store_unit;

    localparam int TB_TIMEOUT = 4;

    logic        sys_clk;
    logic        sys_reset;
    logic        memload_flag;
    logic        memstore_flag;
    logic [2:0]  func3;
    logic [31:0] mem_addr;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        stall;
    logic        done;
    logic        fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic        bus_err;
    logic [31:0] bus_rdata;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        logic        fault;
        logic        chk_data;
        logic [31:0] data;
        string       tag;
    } exp_t;

    exp_t sb_q[$];

    rv32i_load_store_unit #(.TIMEOUT(TB_TIMEOUT), .CNT_W(8)) dut (
        .sys_clk      (sys_clk),
        .sys_reset    (sys_reset),
        .memload_flag (memload_flag),
        .memstore_flag(memstore_flag),
        .func3        (func3),
        .mem_addr     (mem_addr),
        .store_data   (store_data),
        .load_data    (load_data),
        .stall        (stall),
        .done         (done),
        .fault        (fault),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_be       (bus_be),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_err      (bus_err),
        .bus_rdata    (bus_rdata)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Commit monitor: every done pulse must match the oldest queued expectation.
    always @(negedge sys_clk) begin
        if (sys_reset && done) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_done", 128'(1), 128'(0));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_val({e.tag, "_fault"}, 128'(fault), 128'(e.fault));
                if (e.chk_data) check_val({e.tag, "_ldata"}, 128'(load_data), 128'(e.data));
                check_val({e.tag, "_commit_stall_req"}, 128'({stall, bus_req}), 128'(0));
            end
        end
    end

    // One access from IDLE: ack_k = REQ cycle carrying bus_ack (0 = never), noise = stray bus_err.
    task automatic run_access(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] sd, input int ack_k,
                              input logic err, input logic noise, input logic [31:0] rdata);
        logic        bad;
        logic [1:0]  off;
        logic [31:0] sh;
        logic [31:0] ld_val;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        int          e_lat;
        int          e_reqc;
        int          n;
        int          reqc;
        logic        seen;
        exp_t        e;

        off = addr[1:0];
        bad = (ld && st);
        if (ld && !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) bad = 1'b1;
        if (st && !(f3 inside {3'b000, 3'b001, 3'b010})) bad = 1'b1;
        if (f3[1:0] == 2'b01 && off[0]) bad = 1'b1;
        if (f3[1:0] == 2'b10 && off != 2'b00) bad = 1'b1;

        sh = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  ld_val = {{24{sh[7]}}, sh[7:0]};
            3'b001:  ld_val = {{16{sh[15]}}, sh[15:0]};
            3'b100:  ld_val = {24'h0, sh[7:0]};
            3'b101:  ld_val = {16'h0, sh[15:0]};
            default: ld_val = rdata;
        endcase
        case (f3[1:0])
            2'b00:   begin e_be = 4'b0001 << off; e_wd = {4{sd[7:0]}}; end
            2'b01:   begin e_be = off[1] ? 4'b1100 : 4'b0011; e_wd = {2{sd[15:0]}}; end
            default: begin e_be = 4'b1111; e_wd = sd; end
        endcase

        e.tag = tag;
        e.chk_data = ld && !st;
        if (bad) begin
            e.fault = 1'b1; e.data = 32'h0; e_lat = 1; e_reqc = 0;
        end else if (ack_k == 0) begin
            e.fault = 1'b1; e.data = 32'h0; e_lat = TB_TIMEOUT + 1; e_reqc = TB_TIMEOUT;
        end else begin
            e.fault = err; e.data = err ? 32'h0 : ld_val; e_lat = ack_k + 1; e_reqc = ack_k;
        end
        sb_q.push_back(e);

        memload_flag = ld; memstore_flag = st; func3 = f3; mem_addr = addr; store_data = sd;
        #1;
        check_val({tag, "_stall_issue"}, 128'(stall), 128'(1));
        n = 0; reqc = 0; seen = 1'b0;
        while (!seen && n < 300) begin
            @(negedge sys_clk);
            n++;
            memload_flag = 1'b0; memstore_flag = 1'b0;
            bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
            if (done) begin
                seen = 1'b1;
            end else if (bus_req) begin
                reqc++;
                check_val({tag, "_bus"}, {bus_we, bus_addr, bus_be, (st ? bus_wdata : 32'h0), stall},
                          {st, addr & 32'hFFFF_FFFC, e_be, (st ? e_wd : 32'h0), 1'b1});
                if (ack_k > 0 && reqc == ack_k) begin
                    bus_ack = 1'b1; bus_err = err; bus_rdata = rdata;
                end else begin
                    bus_err = noise;
                end
            end
        end
        check_val({tag, "_latency"}, 128'(n), 128'(e_lat));
        check_val({tag, "_req_cycles"}, 128'(reqc), 128'(e_reqc));
        @(negedge sys_clk);
        check_val({tag, "_done_pulse"}, 128'({done, fault}), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_reset = 1'b0;
        memload_flag = 1'b0; memstore_flag = 1'b0; func3 = 3'b000;
        mem_addr = 32'h0; store_data = 32'h0;
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
        #3;
        check_val("reset_outputs",
                  {bus_req, bus_we, bus_addr, bus_be, bus_wdata, load_data, done, fault, stall},
                  128'(0));
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_reset = 1'b1;
        @(negedge sys_clk);

        run_access("sw",       1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 2, 1'b0, 1'b0, 32'h0);
        run_access("lb",       1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'h0, 1, 1'b0, 1'b0, 32'h8011_2233);
        run_access("lbu",      1'b1, 1'b0, 3'b100, 32'h0000_0203, 32'h0, 1, 1'b0, 1'b0, 32'h8011_2233);
        run_access("sh",       1'b0, 1'b1, 3'b001, 32'h0000_0012, 32'h0000_ABCD, 1, 1'b0, 1'b0, 32'h0);
        run_access("lh_mis",   1'b1, 1'b0, 3'b001, 32'h0000_0011, 32'h0, 1, 1'b0, 1'b0, 32'h0);
        run_access("lw_tmo",   1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 0, 1'b0, 1'b0, 32'h0);
        run_access("lw_err",   1'b1, 1'b0, 3'b010, 32'h0000_0044, 32'h0, 1, 1'b1, 1'b0, 32'h1234_5678);
        run_access("both",     1'b1, 1'b1, 3'b010, 32'h0000_0008, 32'h0, 1, 1'b0, 1'b0, 32'h0);
        run_access("lh_hi",    1'b1, 1'b0, 3'b001, 32'h0000_0022, 32'h0, 2, 1'b0, 1'b0, 32'h8001_7FFF);
        run_access("lhu",      1'b1, 1'b0, 3'b101, 32'h0000_0020, 32'h0, 1, 1'b0, 1'b0, 32'h1234_8765);
        run_access("sb_noise", 1'b0, 1'b1, 3'b000, 32'h0000_0031, 32'h0000_00A5, 3, 1'b0, 1'b1, 32'h0);
        run_access("ld_f3ill", 1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0, 1, 1'b0, 1'b0, 32'h0);
        run_access("st_f3ill", 1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h0, 1, 1'b0, 1'b0, 32'h0);
        run_access("sw_mis",   1'b0, 1'b1, 3'b010, 32'h0000_0102, 32'h5555_AAAA, 1, 1'b0, 1'b0, 32'h0);
        run_access("lb_pos",   1'b1, 1'b0, 3'b000, 32'h0000_0001, 32'h0, 1, 1'b0, 1'b0, 32'h0000_7F00);
        run_access("lw_ack4",  1'b1, 1'b0, 3'b010, 32'h0000_0050, 32'h0, 4, 1'b0, 1'b0, 32'hCAFE_F00D);

        // Stray ack while idle must not start or finish anything.
        bus_ack = 1'b1; bus_err = 1'b1;
        @(negedge sys_clk);
        bus_ack = 1'b0; bus_err = 1'b0;
        check_val("idle_ack", {done, fault, bus_req, stall}, 128'(0));
        @(negedge sys_clk);
        check_val("idle_ack_next", {done, fault, bus_req, stall}, 128'(0));

        // Reset in the middle of an access abandons it.
        memload_flag = 1'b1; func3 = 3'b010; mem_addr = 32'h0000_0060;
        @(negedge sys_clk);
        memload_flag = 1'b0;
        check_val("rst_pre_req", 128'(bus_req), 128'(1));
        @(negedge sys_clk);
        sys_reset = 1'b0;
        #1;
        check_val("rst_async_req", {bus_req, stall}, 128'(0));
        @(negedge sys_clk);
        sys_reset = 1'b1;
        @(negedge sys_clk);
        check_val("rst_after", {done, fault, bus_req, stall}, 128'(0));
        run_access("post_rst", 1'b0, 1'b1, 3'b001, 32'h0000_0016, 32'h0000_1357, 1, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < 24; i++) begin
            logic        ld;
            logic [2:0]  f3;
            logic [31:0] a;
            int          k;
            ld = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom & 32'h0000_0FFF;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            k  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TB_TIMEOUT));
            run_access($sformatf("rnd%0d", i), ld, !ld, f3, a, $urandom, k,
                       1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), $urandom);
        end

        check_val("sb_drained", 128'(sb_q.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
